data_memory_port: RTL

DATA_MEMORY_PORT -- requirements
Module: data_memory_port

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 53 +++++
 rtl/data_memory_port.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data memory port: access size codes,
// FSM states and wait-counter width. DMEM_CLEAR_ON_RESET_EN adds CLEAR.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

`ifdef DMEM_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_CLEAR
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;
`endif

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores, extraction/extension for loads.
// Ports: i_size/i_uns/i_off/i_wdata/i_rword in; o_wword/o_wmask/o_rdata/o_misalign out.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [31:0] o_wword,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wword    = i_wdata;
    o_wmask    = '0;
    o_rdata    = '0;
    o_misalign = 1'b0;
    w_byte     = i_rword[{i_off, 3'b000} +: 8];
    w_half     = i_off[1] ? i_rword[31:16] : i_rword[15:0];
    unique case (size_e'(i_size))
      SZ_BYTE: begin
        o_wword = {4{i_wdata[7:0]}};
        o_wmask = 4'b0001 << i_off;
        o_rdata = {{24{w_byte[7] & ~i_uns}}, w_byte};
      end
      SZ_HALF: begin
        o_misalign = i_off[0];
        o_wword    = {2{i_wdata[15:0]}};
        o_wmask    = i_off[1] ? 4'b1100 : 4'b0011;
        o_rdata    = {{16{w_half[15] & ~i_uns}}, w_half};
      end
      default: begin
        // reserved size code behaves as a word access
        o_misalign = |i_off;
        o_wmask    = 4'hF;
        o_rdata    = i_rword;
      end
    endcase
    // a misaligned access touches nothing and returns zero
    if (o_misalign) begin
      o_wmask = '0;
      o_rdata = '0;
    end
  end

endmodule

// File: rtl/data_memory_port.sv
// Single-port 32-bit data memory with fixed-latency request/response handshake.
// Ports: clk, rst, req/we/addr/size/uns/wdata in; busy/resp_valid/rdata/misalign out.
// Macro DMEM_CLEAR_ON_RESET_EN: zero the array word by word after reset.
module data_memory_port
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W+1:0] addr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              misalign
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       r_mem [DEPTH];
  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_rv;
  logic              r_mis;
  logic [31:0]       r_rdata;
  logic              r_we;
  logic [ADDR_W+1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [31:0]       r_wdata;

  logic              w_clr_go;
  logic              w_acc;
  logic              w_enter_resp;
  logic              w_op_we;
  logic [ADDR_W+1:0] w_op_addr;
  logic [1:0]        w_op_size;
  logic              w_op_uns;
  logic [31:0]       w_op_wdata;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_wword;
  logic [3:0]        w_wmask;
  logic [31:0]       w_lrdata;
  logic              w_mis;

`ifdef DMEM_CLEAR_ON_RESET_EN
  logic              r_clr_pend;
  logic [ADDR_W-1:0] r_clr_ptr;
  assign w_clr_go = r_clr_pend;
`else
  assign w_clr_go = 1'b0;
`endif

  assign w_acc = (r_state == S_IDLE) && req && !w_clr_go;

  // with zero wait the access completes on the accept edge,
  // so operands come straight from the inputs while idle
  assign w_op_we    = (r_state == S_IDLE) ? we    : r_we;
  assign w_op_addr  = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_op_size  = (r_state == S_IDLE) ? size  : r_size;
  assign w_op_uns   = (r_state == S_IDLE) ? uns   : r_uns;
  assign w_op_wdata = (r_state == S_IDLE) ? wdata : r_wdata;
  assign w_idx      = w_op_addr[ADDR_W+1:2];

  assign w_enter_resp = !rst &&
    ((w_acc && (WAIT_CYCLES == 0)) ||
     ((r_state == S_WAIT) && (r_cnt == CNT_W'(1))));

  dmem_lane_align u_align (
    .i_size     (w_op_size),
    .i_uns      (w_op_uns),
    .i_off      (w_op_addr[1:0]),
    .i_wdata    (w_op_wdata),
    .i_rword    (r_mem[w_idx]),
    .o_wword    (w_wword),
    .o_wmask    (w_wmask),
    .o_rdata    (w_lrdata),
    .o_misalign (w_mis)
  );

  always_ff @(posedge clk) begin
    if (w_enter_resp && w_op_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (!rst && (r_state == S_CLEAR)) r_mem[r_clr_ptr] <= '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_rv    <= 1'b0;
      r_mis   <= 1'b0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_wdata <= '0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      r_clr_pend <= 1'b1;
      r_clr_ptr  <= '0;
`endif
    end else begin
      r_rv  <= w_enter_resp;
      r_mis <= w_enter_resp & w_mis;
      if (w_enter_resp) r_rdata <= w_op_we ? 32'd0 : w_lrdata;
      unique case (r_state)
        S_IDLE: begin
`ifdef DMEM_CLEAR_ON_RESET_EN
          if (r_clr_pend) begin
            r_clr_pend <= 1'b0;
            r_clr_ptr  <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_CLEAR;
          end
`endif
          if (w_acc) begin
            r_we    <= we;
            r_addr  <= addr;
            r_size  <= size;
            r_uns   <= uns;
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_RESP;
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
`ifdef DMEM_CLEAR_ON_RESET_EN
        S_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
          if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign resp_valid = r_rv;
  assign rdata      = r_rdata;
  assign misalign   = r_mis;

endmodule
